// File: rtl/instr_encoder.sv
// Packs RV-style field sets into 32-bit instruction words, flagging unrepresentable immediates.
// Results queue in a 2-entry FIFO; output is registered, so a request shows one edge after acceptance.
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [63:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ins,
  output logic        out_err,
  output logic [15:0] enc_count
);

  localparam logic [1:0] FMT_R  = 2'b00;
  localparam logic [1:0] FMT_I  = 2'b01;
  localparam logic [1:0] FMT_S  = 2'b10;
  localparam logic [1:0] FMT_SB = 2'b11;

  logic [31:0] enc_ins;
  logic        enc_err;
  logic        fits_12;
  logic        fits_13;

  // Sign-extended immediate fits N bits when every bit above N-1 matches the sign bit.
  assign fits_12 = (&imm[63:11]) | ~(|imm[63:11]);
  assign fits_13 = (&imm[63:12]) | ~(|imm[63:12]);

  always_comb begin
    enc_ins = '0;
    enc_err = 1'b0;
    case (fmt)
      FMT_R: begin
        enc_ins = {funct7, rs2, rs1, funct3, rd, opcode};
        enc_err = 1'b0;
      end
      FMT_I: begin
        enc_ins = {imm[11:0], rs1, funct3, rd, opcode};
        enc_err = ~fits_12;
      end
      FMT_S: begin
        enc_ins = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_err = ~fits_12;
      end
      FMT_SB: begin
        enc_ins = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_err = ~fits_13 | imm[0];
      end
      default: begin
        enc_ins = '0;
        enc_err = 1'b0;
      end
    endcase
  end

  logic [32:0] mem_head;
  logic [32:0] mem_tail;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_ins   = mem_head[32:1];
  assign out_err   = mem_head[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_head  <= '0;
      mem_tail  <= '0;
      count     <= 2'd0;
      enc_count <= 16'd0;
    end else begin
      if (push) begin
        enc_count <= enc_count + 16'd1;
      end
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            mem_head <= {enc_ins, enc_err};
          end else begin
            mem_tail <= {enc_ins, enc_err};
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          mem_head <= mem_tail;
          count    <= count - 2'd1;
        end
        2'b11: begin
          // Push can only coincide with pop below full, so the head is replaced or shifted.
          if (count == 2'd1) begin
            mem_head <= {enc_ins, enc_err};
          end else begin
            mem_head <= mem_tail;
            mem_tail <= {enc_ins, enc_err};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words queued at drive time, compared at the FIFO head.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [63:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic        out_err;
  logic [15:0] enc_count;

  int total = 0;
  int bad = 0;
  logic [32:0] sbq[$];

  instr_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_ins(out_ins),
    .out_err(out_err), .enc_count(enc_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [1:0]  f;
    logic [6:0]  op;
    logic [4:0]  d;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] im;
    logic [31:0] ins;
    logic        err;
  } vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [63:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  // Reference packing written straight from the format table.
  function automatic logic [32:0] model_now();
    logic [31:0] w;
    logic e;
    logic hi12_ok, hi13_ok;
    hi12_ok = (imm[63:11] == '0) || (imm[63:11] == '1);
    hi13_ok = (imm[63:12] == '0) || (imm[63:12] == '1);
    case (fmt)
      2'b00: begin w = {funct7, rs2, rs1, funct3, rd, opcode}; e = 1'b0; end
      2'b01: begin w = {imm[11:0], rs1, funct3, rd, opcode}; e = !hi12_ok; end
      2'b10: begin w = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; e = !hi12_ok; end
      default: begin
        w = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        e = !hi13_ok || imm[0];
      end
    endcase
    return {w, e};
  endfunction

  task automatic rand_req;
    logic [12:0] s;
    s = 13'($urandom);
    set_req(2'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            3'($urandom), 7'($urandom), {{51{s[12]}}, s});
    if ($urandom_range(0, 4) == 0) imm = {$urandom, $urandom};
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_req(2'b00, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    repeat (2) tick;
    total++; if (out_ins !== 32'h0) begin bad++; $display("FAIL reset_out_ins got=%h want=00000000", out_ins); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%b want=0", out_err); end
    total++; if (enc_count !== 16'd0) begin bad++; $display("FAIL reset_enc_count got=%0d want=0", enc_count); end
    reset = 1'b0;
  endtask

  task automatic test_vectors;
    vec_t v[11];
    logic [15:0] cnt_before;
    logic [32:0] exp;
    v[0]  = '{2'b01, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'd5, 32'h00500093, 1'b0};
    v[1]  = '{2'b10, 7'h23, 5'd0, 5'd1, 5'd2, 3'd3, 7'h00, 64'd8, 32'h0020B423, 1'b0};
    v[2]  = '{2'b00, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 64'd0, 32'h002081B3, 1'b0};
    v[3]  = '{2'b11, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFE208EE3, 1'b0};
    v[4]  = '{2'b11, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 64'd3, 32'h00208163, 1'b1};
    v[5]  = '{2'b01, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'd2048, 32'h80000093, 1'b1};
    v[6]  = '{2'b00, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 64'hDEAD_BEEF_0000_0001, 32'h402081B3, 1'b0};
    v[7]  = '{2'b01, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_F800, 32'h80000093, 1'b0};
    v[8]  = '{2'b10, 7'h23, 5'd0, 5'd1, 5'd2, 3'd3, 7'h00, 64'hFFFF_FFFF_FFFF_F7FF, 32'h7E20BFA3, 1'b1};
    v[9]  = '{2'b11, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 64'd4094, 32'h7E208FE3, 1'b0};
    v[10] = '{2'b11, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 64'd4096, 32'h80208063, 1'b1};
    for (int i = 0; i < 11; i++) begin
      set_req(v[i].f, v[i].op, v[i].d, v[i].s1, v[i].s2, v[i].f3, v[i].f7, v[i].im);
      in_valid = 1'b1;
      sbq.push_back({v[i].ins, v[i].err});
      cnt_before = enc_count;
      tick;
      in_valid = 1'b0;
      exp = sbq.pop_front();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL vec%0d_valid got=%b want=1", i, out_valid); end
      total++; if (out_ins !== exp[32:1]) begin bad++; $display("FAIL vec%0d_ins got=%h want=%h", i, out_ins, exp[32:1]); end
      total++; if (out_err !== exp[0]) begin bad++; $display("FAIL vec%0d_err got=%b want=%b", i, out_err, exp[0]); end
      total++; if (enc_count !== cnt_before + 16'd1) begin bad++; $display("FAIL vec%0d_count got=%0d want=%0d", i, enc_count, cnt_before + 16'd1); end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL vec%0d_drained got=%b want=0", i, out_valid); end
    end
  endtask

  task automatic test_random;
    logic [32:0] exp;
    out_ready = 1'b1;
    tick;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL empty_pop valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready); end
    out_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rand_req();
      in_valid = 1'b1;
      sbq.push_back(model_now());
      tick;
      in_valid = 1'b0;
      exp = sbq.pop_front();
      total++; if ({out_valid, out_ins, out_err} !== {1'b1, exp}) begin bad++; $display("FAIL rand%0d got=%b/%h/%b want=1/%h/%b", i, out_valid, out_ins, out_err, exp[32:1], exp[0]); end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure;
    int sent = 0;
    int got = 0;
    logic acc, pp;
    out_ready = 1'b0;
    rand_req();
    in_valid = 1'b1;
    sbq.push_back(model_now());
    for (int c = 0; c < 60 && got < 3; c++) begin
      acc = in_valid && in_ready;
      pp = out_valid && out_ready;
      if (out_valid && sbq.size() > 0) begin
        total++; if ({out_ins, out_err} !== sbq[0]) begin bad++; $display("FAIL bp_head c=%0d got=%h/%b want=%h/%b", c, out_ins, out_err, sbq[0][32:1], sbq[0][0]); end
      end
      if (c >= 2 && c <= 5) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full c=%0d in_ready got=%b want=0", c, in_ready); end
      end
      tick;
      if (pp) begin void'(sbq.pop_front()); got++; end
      if (acc) begin
        sent++;
        if (sent < 3) begin rand_req(); sbq.push_back(model_now()); end
        else in_valid = 1'b0;
      end
      if (c == 6) out_ready = 1'b1;
    end
    total++; if (got != 3) begin bad++; $display("FAIL bp_emitted got=%0d want=3", got); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", out_valid); end
    out_ready = 1'b0;
    in_valid = 1'b0;
    sbq.delete();
  endtask

  task automatic test_back_to_back;
    int n = 0;
    logic acc, pp;
    out_ready = 1'b1;
    rand_req();
    in_valid = 1'b1;
    sbq.push_back(model_now());
    for (int c = 0; c < 60 && (c == 0 || sbq.size() > 0); c++) begin
      acc = in_valid && in_ready;
      pp = out_valid && out_ready;
      if (c > 0 && c < 20) begin
        total++; if ({out_valid, in_ready} !== 2'b11) begin bad++; $display("FAIL b2b_occ c=%0d valid=%b ready=%b want 1/1", c, out_valid, in_ready); end
        total++; if ({out_ins, out_err} !== sbq[0]) begin bad++; $display("FAIL b2b_head c=%0d got=%h/%b want=%h/%b", c, out_ins, out_err, sbq[0][32:1], sbq[0][0]); end
      end
      tick;
      if (pp) void'(sbq.pop_front());
      if (acc) begin
        n++;
        if (n < 20) begin rand_req(); sbq.push_back(model_now()); end
        else in_valid = 1'b0;
      end
    end
    total++; if (sbq.size() != 0 || out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain left=%0d valid=%b want 0/0", sbq.size(), out_valid); end
    out_ready = 1'b0;
    sbq.delete();
  endtask

  task automatic test_reset_midop;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_req();
      in_valid = 1'b1;
      sbq.push_back(model_now());
      tick;
    end
    in_valid = 1'b0;
    total++; if ({out_valid, in_ready, enc_count} !== {2'b10, 16'd2}) begin bad++; $display("FAIL pre_reset valid=%b ready=%b count=%0d want 1/0/2", out_valid, in_ready, enc_count); end
    #2 reset = 1'b1;
    #1;
    total++; if ({out_valid, in_ready, enc_count} !== {2'b01, 16'd0}) begin bad++; $display("FAIL async_reset valid=%b ready=%b count=%0d want 0/1/0", out_valid, in_ready, enc_count); end
    total++; if ({out_ins, out_err} !== 33'd0) begin bad++; $display("FAIL async_reset_data got=%h/%b want=0/0", out_ins, out_err); end
    sbq.delete();
    tick;
    reset = 1'b0;
    rand_req();
    in_valid = 1'b1;
    sbq.push_back(model_now());
    tick;
    in_valid = 1'b0;
    total++; if ({out_valid, enc_count} !== {1'b1, 16'd1}) begin bad++; $display("FAIL first_accept valid=%b count=%0d want 1/1", out_valid, enc_count); end
    total++; if ({out_ins, out_err} !== sbq[0]) begin bad++; $display("FAIL first_accept_data got=%h/%b want=%h/%b", out_ins, out_err, sbq[0][32:1], sbq[0][0]); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    sbq.delete();
  endtask

  task automatic test_count_wrap;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    set_req(2'b01, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd5);
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (65535) tick;
    total++; if (enc_count !== 16'hFFFF) begin bad++; $display("FAIL count_max got=%h want=FFFF", enc_count); end
    tick;
    total++; if (enc_count !== 16'h0000) begin bad++; $display("FAIL count_wrap got=%h want=0000", enc_count); end
    in_valid = 1'b0;
    tick;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_drain got=%b want=0", out_valid); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_random;
    test_backpressure;
    test_back_to_back;
    test_reset_midop;
    test_count_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have these ports (name  direction  width  meaning):
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request carries a field set to encode.
- in_ready  output  1  block can accept a request this cycle.
- fmt  input  2  format: 00 R, 01 I, 10 S, 11 SB.
- opcode  input  7  ins[6:0].
- rd  input  5  destination register (R/I only).
- rs1  input  5  source register 1 (all formats).
- rs2  input  5  source register 2 (R/S/SB only).
- funct3  input  3  ins[14:12].
- funct7  input  7  ins[31:25] (R only).
- imm  input  64  sign-extended immediate, same form the decode side produces.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer takes the head entry this cycle.
- out_ins  output  32  encoded instruction word.
- out_err  output  1  immediate not representable in the selected format.
- enc_count  output  16  number of requests accepted since reset.

Function
REQ-002 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-003 Encoding SHALL follow these formats; inputs not listed for a format SHALL be ignored:
- R: {funct7, rs2, rs1, funct3, rd, opcode}
- I: {imm[11:0], rs1, funct3, rd, opcode}
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
- SB: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
REQ-004 out_err SHALL be:
- I/S: 1 when imm[63:11] is not all-equal;
- SB: 1 when imm[63:12] is not all-equal or imm[0]=1;
- R: always 0.
REQ-005 When out_err=1, out_ins SHALL still contain the truncated packing of REQ-003.
REQ-006 Encoded words SHALL be stored in a 2-entry FIFO, entries {out_ins, out_err}, emitted strictly in acceptance order.
REQ-007 in_ready SHALL be 1 exactly when the FIFO holds fewer than 2 entries; it depends on registered occupancy only, not on out_ready.
REQ-008 out_valid SHALL be 1 exactly when the FIFO holds at least 1 entry; out_ins and out_err SHALL always show the head entry.
REQ-009 Latency: a request accepted at edge N into an empty FIFO SHALL appear on out_ins/out_valid after edge N.
REQ-010 A pop SHALL occur on an edge where out_valid and out_ready are both 1.
REQ-011 Simultaneous push and pop with 1 entry held SHALL leave occupancy at 1, with the new word at the head.
REQ-012 Occupancy SHALL never exceed 2 or go below 0; out_ready with an empty FIFO SHALL have no effect.
REQ-013 out_ins and out_err SHALL hold their value while out_valid=1 and out_ready=0.
REQ-014 enc_count SHALL increment by 1 per accepted request and wrap from 0xFFFF to 0x0000.

Reset
REQ-015 While reset=1, regardless of clk: FIFO empty, out_valid=0, in_ready=1, out_ins=0x00000000, out_err=0, enc_count=0.
REQ-016 Asserting reset mid-operation SHALL discard all FIFO contents.
REQ-017 The first acceptance SHALL occur at the first rising edge after reset deasserts with in_valid=1.

Verification
REQ-018 I, opcode=0010011, rd=1, rs1=0, funct3=0, imm=5 -> out_ins=0x00500093, out_err=0, one cycle after acceptance.
REQ-019 S, opcode=0100011, rs1=1, rs2=2, funct3=3, imm=8 -> 0x0020B423; R, opcode=0110011, rd=3, rs1=1, rs2=2, funct3=0, funct7=0 -> 0x002081B3.
REQ-020 SB, opcode=1100011, rs1=1, rs2=2, funct3=0, imm=-4 -> 0xFE208EE3, err=0; same request with imm=3 -> err=1; I request with imm=2048 -> err=1.
REQ-021 Backpressure: hold out_ready=0 and push 3 requests -> in_ready=0 after 2 pushes, third waits; release out_ready -> all 3 emitted in order, head stable while stalled.
REQ-022 Assert reset with 2 entries queued and enc_count=2 -> out_valid=0, in_ready=1, enc_count=0 immediately; preload enc_count to 0xFFFF via 65535 accepts, one more accept -> 0x0000.
